// File: rtl/cache_mem_arbiter.sv
// Merges the icache/dcache memory request streams onto one memory port and routes
// in-order memory responses back to the issuing cache via a source-ID FIFO.
module cache_mem_arbiter #(
    parameter int unsigned p_max_outstanding = 4
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        cache0_req_val,
    output logic        cache0_req_rdy,
    input  logic [76:0] cache0_req_msg,
    output logic        cache0_resp_val,
    input  logic        cache0_resp_rdy,
    output logic [46:0] cache0_resp_msg,

    input  logic        cache1_req_val,
    output logic        cache1_req_rdy,
    input  logic [76:0] cache1_req_msg,
    output logic        cache1_resp_val,
    input  logic        cache1_resp_rdy,
    output logic [46:0] cache1_resp_msg,

    output logic        memreq_val,
    input  logic        memreq_rdy,
    output logic [76:0] memreq_msg,
    input  logic        memresp_val,
    output logic        memresp_rdy,
    input  logic [46:0] memresp_msg
);

    localparam int unsigned PtrW = $clog2(p_max_outstanding);
    localparam logic [PtrW:0]   CountFull = (PtrW + 1)'(p_max_outstanding);
    localparam logic [PtrW:0]   CountOne  = (PtrW + 1)'(1);
    localparam logic [PtrW-1:0] PtrOne    = PtrW'(1);

    logic                         prio_q;
    logic [p_max_outstanding-1:0] fifo_q;
    logic [PtrW-1:0]              head_q;
    logic [PtrW-1:0]              tail_q;
    logic [PtrW:0]                count_q;

    logic full;
    logic empty;
    logic grant;
    logic head_src;
    logic push;
    logic pop;

    // Request side: pure pass-through of the granted port.
    always_comb begin
        full  = (count_q == CountFull);
        empty = (count_q == '0);

        if (cache0_req_val && cache1_req_val) begin
            grant = prio_q;
        end else begin
            grant = cache1_req_val;
        end

        memreq_val     = (cache0_req_val | cache1_req_val) & ~full;
        memreq_msg     = grant ? cache1_req_msg : cache0_req_msg;
        cache0_req_rdy = ~grant & memreq_rdy & ~full;
        cache1_req_rdy = grant & memreq_rdy & ~full;
        push           = memreq_val & memreq_rdy;
    end

    // Response side: an empty FIFO stalls stray responses instead of dropping them.
    always_comb begin
        head_src        = fifo_q[head_q];
        cache0_resp_msg = memresp_msg;
        cache1_resp_msg = memresp_msg;
        cache0_resp_val = ~empty & ~head_src & memresp_val;
        cache1_resp_val = ~empty & head_src & memresp_val;
        memresp_rdy     = ~empty & (head_src ? cache1_resp_rdy : cache0_resp_rdy);
        pop             = memresp_val & memresp_rdy;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prio_q  <= 1'b0;
            fifo_q  <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                fifo_q[tail_q] <= grant;
                tail_q         <= tail_q + PtrOne;
                prio_q         <= ~grant;
            end
            if (pop) begin
                head_q <= head_q + PtrOne;
            end
            unique case ({push, pop})
                2'b10:   count_q <= count_q + CountOne;
                2'b01:   count_q <= count_q - CountOne;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Scoreboard bench for cache_mem_arbiter: stimulus queues expected memory requests and
// per-cache responses; a negedge monitor pops and compares on every fired transfer.
module tb_cache_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        cache0_req_val, cache0_req_rdy, cache0_resp_val, cache0_resp_rdy;
    logic [76:0] cache0_req_msg;
    logic [46:0] cache0_resp_msg;
    logic        cache1_req_val, cache1_req_rdy, cache1_resp_val, cache1_resp_rdy;
    logic [76:0] cache1_req_msg;
    logic [46:0] cache1_resp_msg;
    logic        memreq_val, memreq_rdy, memresp_val, memresp_rdy;
    logic [76:0] memreq_msg;
    logic [46:0] memresp_msg;

    int tests = 0;
    int fails = 0;

    // Expected memreq entries are {cache1_req_rdy, cache0_req_rdy, msg}.
    logic [78:0] exp_req_q[$];
    logic [46:0] exp_r0_q[$];
    logic [46:0] exp_r1_q[$];

    always #5 clk = ~clk;

    cache_mem_arbiter #(.p_max_outstanding(4)) dut (
        .clk             (clk),
        .reset           (reset),
        .cache0_req_val  (cache0_req_val),
        .cache0_req_rdy  (cache0_req_rdy),
        .cache0_req_msg  (cache0_req_msg),
        .cache0_resp_val (cache0_resp_val),
        .cache0_resp_rdy (cache0_resp_rdy),
        .cache0_resp_msg (cache0_resp_msg),
        .cache1_req_val  (cache1_req_val),
        .cache1_req_rdy  (cache1_req_rdy),
        .cache1_req_msg  (cache1_req_msg),
        .cache1_resp_val (cache1_resp_val),
        .cache1_resp_rdy (cache1_resp_rdy),
        .cache1_resp_msg (cache1_resp_msg),
        .memreq_val      (memreq_val),
        .memreq_rdy      (memreq_rdy),
        .memreq_msg      (memreq_msg),
        .memresp_val     (memresp_val),
        .memresp_rdy     (memresp_rdy),
        .memresp_msg     (memresp_msg)
    );

    function automatic logic [76:0] mk_req(input logic [7:0] opq, input logic [31:0] addr);
        return {3'd0, opq, addr, 2'd0, 32'd0};
    endfunction

    function automatic logic [46:0] mk_resp(input logic [7:0] opq, input logic [31:0] data);
        return {3'd0, opq, 2'd0, 2'd0, data};
    endfunction

    task automatic chk(input string name, input logic [78:0] got, input logic [78:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, got, want);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every fired transfer must match the head of its scoreboard queue.
    always @(negedge clk) begin
        if (!reset) begin
            if (memreq_val && memreq_rdy) begin
                if (exp_req_q.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL memreq_unexpected: got %h expected none", memreq_msg);
                end else begin
                    chk("memreq", {cache1_req_rdy, cache0_req_rdy, memreq_msg},
                        exp_req_q.pop_front());
                end
            end
            if (cache0_resp_val && cache0_resp_rdy) begin
                if (exp_r0_q.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL c0_resp_unexpected: got %h expected none", cache0_resp_msg);
                end else begin
                    chk("c0_resp", {32'd0, cache0_resp_msg}, {32'd0, exp_r0_q.pop_front()});
                end
            end
            if (cache1_resp_val && cache1_resp_rdy) begin
                if (exp_r1_q.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL c1_resp_unexpected: got %h expected none", cache1_resp_msg);
                end else begin
                    chk("c1_resp", {32'd0, cache1_resp_msg}, {32'd0, exp_r1_q.pop_front()});
                end
            end
        end
    end

    // Both ports request for 4 cycles (alternating grants from prio=0), then full on cycle 5.
    task automatic alt_fill(input logic [7:0] t0, input logic [7:0] t1);
        int a = 0;
        int b = 0;
        memreq_rdy     = 1'b1;
        cache0_req_val = 1'b1;
        cache1_req_val = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cache0_req_msg = mk_req(8'(t0 + 8'(a)), 32'(32'h2000 + 4 * a));
            cache1_req_msg = mk_req(8'(t1 + 8'(b)), 32'(32'h3000 + 4 * b));
            if (i % 2 == 0) begin
                exp_req_q.push_back({2'b01, cache0_req_msg});
                a++;
            end else begin
                exp_req_q.push_back({2'b10, cache1_req_msg});
                b++;
            end
            #1;
            chk("alt_grant", {77'd0, cache1_req_rdy, cache0_req_rdy},
                (i % 2 == 0) ? 79'd1 : 79'd2);
            cyc();
        end
        cache0_req_msg = mk_req(8'(t0 + 8'd2), 32'h2008);
        cache1_req_msg = mk_req(8'(t1 + 8'd2), 32'h3008);
        #1;
        chk("full_memreq_val", {78'd0, memreq_val}, 79'd0);
        chk("full_req_rdys", {77'd0, cache1_req_rdy, cache0_req_rdy}, 79'd0);
    endtask

    initial begin
        reset = 1'b1;
        cache0_req_val = 0; cache0_req_msg = '0; cache0_resp_rdy = 0;
        cache1_req_val = 0; cache1_req_msg = '0; cache1_resp_rdy = 0;
        memreq_rdy = 0; memresp_val = 0; memresp_msg = '0;
        cyc();
        cyc();
        reset = 1'b0;
        #1;
        chk("reset_outputs", {73'd0, memreq_val, cache0_req_rdy, cache1_req_rdy,
            cache0_resp_val, cache1_resp_val, memresp_rdy}, 79'd0);

        // Stray response with an empty FIFO is stalled.
        memresp_val = 1; memresp_msg = mk_resp(8'hee, 32'hdead);
        cache0_resp_rdy = 1; cache1_resp_rdy = 1;
        #1;
        chk("stray_stall", {76'd0, memresp_rdy, cache0_resp_val, cache1_resp_val}, 79'd0);
        cyc();
        chk("stray_stall2", {78'd0, memresp_rdy}, 79'd0);
        memresp_val = 0;

        // cache0-only reads, responses to cache0.
        memreq_rdy = 1; cache0_req_val = 1;
        cache0_req_msg = mk_req(8'h00, 32'h1000);
        exp_req_q.push_back({2'b01, cache0_req_msg});
        #1;
        chk("c0_only_rdys", {76'd0, memreq_val, cache1_req_rdy, cache0_req_rdy}, 79'd5);
        cyc();
        cache0_req_msg = mk_req(8'h01, 32'h1004);
        exp_req_q.push_back({2'b01, cache0_req_msg});
        cyc();
        cache0_req_val = 0;
        for (int i = 0; i < 2; i++) begin
            memresp_val = 1; memresp_msg = mk_resp(8'(i), 32'(32'h11110000 + i));
            exp_r0_q.push_back(memresp_msg);
            #1;
            chk("c0_only_route", {77'd0, cache1_resp_val, memresp_rdy}, 79'd1);
            cyc();
        end
        memresp_val = 0;

        reset = 1; cyc(); reset = 0;

        // Alternating fill to full, then a pop while full.
        alt_fill(8'h20, 8'h30);
        memresp_val = 1; memresp_msg = mk_resp(8'h20, 32'h5a000000);
        exp_r0_q.push_back(memresp_msg);
        #1;
        chk("full_pop_no_push", {76'd0, memreq_val, memresp_rdy, cache0_resp_val}, 79'd3);
        cyc();
        memresp_val = 0;
        exp_req_q.push_back({2'b01, cache0_req_msg});
        #1;
        chk("push_after_pop", {76'd0, memreq_val, cache1_req_rdy, cache0_req_rdy}, 79'd5);
        cyc();
        cache0_req_msg = mk_req(8'h23, 32'h200c);
        #1;
        chk("full_again", {76'd0, memreq_val, cache1_req_rdy, cache0_req_rdy}, 79'd0);
        cache0_req_val = 0; cache1_req_val = 0;

        // FIFO now holds sources 1,0,1,0: responses must alternate.
        for (int i = 0; i < 4; i++) begin
            memresp_val = 1; memresp_msg = mk_resp(8'(8'h40 + i), 32'(i));
            if (i % 2 == 0) exp_r1_q.push_back(memresp_msg);
            else            exp_r0_q.push_back(memresp_msg);
            #1;
            chk("drain_route", {77'd0, cache1_resp_val, cache0_resp_val},
                (i % 2 == 0) ? 79'd2 : 79'd1);
            cyc();
        end
        memresp_val = 0;

        // cache1 response backpressure.
        cache1_req_val = 1; cache1_req_msg = mk_req(8'h50, 32'h4000);
        exp_req_q.push_back({2'b10, cache1_req_msg});
        cyc();
        cache1_req_msg = mk_req(8'h51, 32'h4004);
        exp_req_q.push_back({2'b10, cache1_req_msg});
        cyc();
        cache1_req_val = 0;
        cache1_resp_rdy = 0; cache0_resp_rdy = 1;
        memresp_val = 1; memresp_msg = mk_resp(8'h50, 32'hc1000000);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("c1_stall", {76'd0, memresp_rdy, cache0_resp_val, cache1_resp_val}, 79'd1);
            cyc();
        end
        cache1_resp_rdy = 1;
        exp_r1_q.push_back(memresp_msg);
        #1;
        chk("c1_drain0", {78'd0, memresp_rdy}, 79'd1);
        cyc();
        memresp_msg = mk_resp(8'h51, 32'hc1000004);
        exp_r1_q.push_back(memresp_msg);
        #1;
        chk("c1_drain1", {78'd0, memresp_rdy}, 79'd1);
        cyc();
        memresp_msg = mk_resp(8'h52, 32'hbad);
        #1;
        chk("drained_empty", {76'd0, memresp_rdy, cache0_resp_val, cache1_resp_val}, 79'd0);
        memresp_val = 0;

        // Reset with 3 outstanding clears FIFO and prio.
        cache0_req_val = 1;
        for (int i = 0; i < 3; i++) begin
            cache0_req_msg = mk_req(8'(8'h60 + i), 32'(32'h6000 + 4 * i));
            exp_req_q.push_back({2'b01, cache0_req_msg});
            cyc();
        end
        cache0_req_val = 0;
        reset = 1; cyc(); reset = 0;
        memresp_val = 1; memresp_msg = mk_resp(8'h66, 32'h0);
        #1;
        chk("post_reset_empty", {76'd0, memresp_rdy, cache0_resp_val, cache1_resp_val}, 79'd0);
        memresp_val = 0;
        alt_fill(8'h70, 8'h80);
        cache0_req_val = 0; cache1_req_val = 0;

        cyc();
        cyc();
        chk("req_queue_drained", 79'(exp_req_q.size()), 79'd0);
        chk("r0_queue_drained", 79'(exp_r0_q.size()), 79'd0);
        chk("r1_queue_drained", 79'(exp_r1_q.size()), 79'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
